// File: rtl/result_requant_writer.sv
// result_requant_writer
// Streams a finished result matrix out of result SRAM, requantises each
// element (optional ReLU, arithmetic right shift, signed 16-bit saturation)
// and writes it to scratchpad SRAM as a header word {rows, cols} at dst_base
// followed by the elements in row-major order from dst_base+1.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start / ready       job request, accepted only while ready=1
//   done                one-cycle pulse when the job completes
//   num_rows, num_cols  matrix shape (latched at start)
//   src_base, dst_base  result SRAM start / scratchpad header address (latched)
//   shift, relu_en      requantisation controls (latched)
//   result_rd_addr      result SRAM read address (data valid one cycle later)
//   result_rd_data      result SRAM read data
//   scr_we/addr/wdata   scratchpad write port
//   sat_count           number of saturated elements in current/last job
module result_requant_writer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               ready,
  output logic               done,
  input  logic [15:0]        num_rows,
  input  logic [15:0]        num_cols,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               relu_en,
  output logic [ADDR_W-1:0]  result_rd_addr,
  input  logic [DATA_W-1:0]  result_rd_data,
  output logic               scr_we,
  output logic [ADDR_W-1:0]  scr_addr,
  output logic [DATA_W-1:0]  scr_wdata,
  output logic [15:0]        sat_count
);

  typedef enum logic [2:0] {IDLE, HEADER, ISSUE, DRAIN1, DRAIN2, DONE} state_t;

  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(32767);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-32768);

  state_t              state;
  logic [15:0]         rows_q;
  logic [15:0]         cols_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic                relu_q;
  logic [31:0]         n_total;
  logic [31:0]         issued;
  logic [ADDR_W-1:0]   wr_addr;

  // Read pipeline: rd_vld marks a valid address on result_rd_addr,
  // dat_pend marks SRAM data arriving this cycle, dat_vld marks dat_q valid.
  logic                rd_vld;
  logic                dat_pend;
  logic                dat_vld;
  logic [DATA_W-1:0]   dat_q;

  logic signed [DATA_W-1:0] x_relu;
  logic signed [DATA_W-1:0] y_shift;
  logic [DATA_W-1:0]        proc_val;
  logic                     proc_sat;

  always_comb begin
    x_relu = signed'(dat_q);
    if (relu_q && (x_relu < 0)) begin
      x_relu = '0;
    end
    y_shift  = x_relu >>> shift_q;
    proc_sat = 1'b0;
    proc_val = y_shift;
    if (y_shift > SAT_MAX) begin
      proc_val = SAT_MAX;
      proc_sat = 1'b1;
    end else if (y_shift < SAT_MIN) begin
      proc_val = SAT_MIN;
      proc_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ready          <= 1'b1;
      done           <= 1'b0;
      scr_we         <= 1'b0;
      scr_addr       <= '0;
      scr_wdata      <= '0;
      result_rd_addr <= '0;
      sat_count      <= '0;
      rows_q         <= '0;
      cols_q         <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      shift_q        <= '0;
      relu_q         <= 1'b0;
      n_total        <= '0;
      issued         <= '0;
      wr_addr        <= '0;
      rd_vld         <= 1'b0;
      dat_pend       <= 1'b0;
      dat_vld        <= 1'b0;
      dat_q          <= '0;
    end else begin
      scr_we   <= 1'b0;
      done     <= 1'b0;
      dat_pend <= rd_vld;
      dat_vld  <= dat_pend;
      if (dat_pend) begin
        dat_q <= result_rd_data;
      end
      if (dat_vld) begin
        scr_we    <= 1'b1;
        scr_addr  <= wr_addr;
        scr_wdata <= proc_val;
        wr_addr   <= wr_addr + ADDR_W'(1);
        if (proc_sat && (sat_count != 16'hFFFF)) begin
          sat_count <= sat_count + 16'd1;
        end
      end

      case (state)
        IDLE: begin
          ready <= 1'b1;
          // Gating on the ready register (not just the state) ignores a start
          // seen in the cycle done is high, which is already spent in IDLE.
          if (start && ready) begin
            rows_q    <= num_rows;
            cols_q    <= num_cols;
            src_q     <= src_base;
            dst_q     <= dst_base;
            shift_q   <= shift;
            relu_q    <= relu_en;
            n_total   <= 32'(num_rows) * 32'(num_cols);
            sat_count <= '0;
            ready     <= 1'b0;
            state     <= HEADER;
          end
        end
        HEADER: begin
          scr_we         <= 1'b1;
          scr_addr       <= dst_q;
          scr_wdata      <= DATA_W'({rows_q, cols_q});
          wr_addr        <= dst_q + ADDR_W'(1);
          result_rd_addr <= src_q;
          issued         <= 32'd1;
          if (n_total == 32'd0) begin
            // Empty matrix: done rides along with the header write.
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rd_vld <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (issued == n_total) begin
            rd_vld <= 1'b0;
            state  <= DRAIN1;
          end else begin
            result_rd_addr <= result_rd_addr + ADDR_W'(1);
            issued         <= issued + 32'd1;
          end
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: state <= DONE;
        DONE: begin
          // The empty-matrix path already pulsed done from HEADER.
          done  <= (n_total != 32'd0);
          ready <= (n_total == 32'd0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_requant_writer.sv
module tb_result_requant_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        ready;
  logic        done;
  logic [15:0] num_rows = '0;
  logic [15:0] num_cols = '0;
  logic [11:0] src_base = '0;
  logic [11:0] dst_base = '0;
  logic [4:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic [11:0] result_rd_addr;
  logic [31:0] result_rd_data = '0;
  logic        scr_we;
  logic [11:0] scr_addr;
  logic [31:0] scr_wdata;
  logic [15:0] sat_count;

  int errors = 0;
  int checks = 0;

  result_requant_writer #(.DATA_W(32), .ADDR_W(12), .SHIFT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .done(done),
    .num_rows(num_rows), .num_cols(num_cols), .src_base(src_base),
    .dst_base(dst_base), .shift(shift), .relu_en(relu_en),
    .result_rd_addr(result_rd_addr), .result_rd_data(result_rd_data),
    .scr_we(scr_we), .scr_addr(scr_addr), .scr_wdata(scr_wdata),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Result SRAM model: registered read, data valid one cycle after address.
  logic [31:0] rmem [0:4095];
  always @(posedge clk) result_rd_data <= rmem[result_rd_addr];

  // Monitor: samples on the falling edge; job_cyc is the cycle number
  // relative to job acceptance (cycle 0 = first cycle after accepting edge).
  logic [11:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          job_cyc = 1000;
  int          done_n = 0;
  int          done_cyc = -1;
  logic [11:0] rd_log [0:63];
  logic        rdy_log [0:63];

  always @(negedge clk) begin
    if (scr_we) begin
      wq_addr.push_back(scr_addr);
      wq_data.push_back(scr_wdata);
      wq_cyc.push_back(job_cyc);
    end
    if (done) begin
      done_n = done_n + 1;
      if (done_cyc < 0) done_cyc = job_cyc;
    end
    if (job_cyc >= 0 && job_cyc < 64) begin
      rd_log[job_cyc]  = result_rd_addr;
      rdy_log[job_cyc] = ready;
    end
    job_cyc = job_cyc + 1;
  end

  task automatic launch(input logic [15:0] r, input logic [15:0] c,
                        input logic [11:0] s, input logic [11:0] d,
                        input logic [4:0] sh, input logic rl);
    @(negedge clk);
    num_rows = r; num_cols = c; src_base = s; dst_base = d;
    shift = sh; relu_en = rl; start = 1'b1;
    @(posedge clk);
    job_cyc = 0; done_n = 0; done_cyc = -1;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (done_n == 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_n == 0) begin
      errors++;
      $display("FAIL %s timeout: done not seen within 200 cycles", tag);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks += 7;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (scr_we !== 1'b0) begin errors++; $display("FAIL reset_scr_we got=%b exp=0", scr_we); end
    if (scr_addr !== 12'h000) begin errors++; $display("FAIL reset_scr_addr got=%h exp=000", scr_addr); end
    if (scr_wdata !== 32'h0) begin errors++; $display("FAIL reset_scr_wdata got=%h exp=0", scr_wdata); end
    if (result_rd_addr !== 12'h000) begin errors++; $display("FAIL reset_rd_addr got=%h exp=000", result_rd_addr); end
    if (sat_count !== 16'h0) begin errors++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
  endtask

  task automatic test_basic();
    logic [11:0] ea [0:6];
    logic [31:0] ed [0:6];
    int          ec [0:6];
    ea[0] = 12'h100; ed[0] = 32'h0002_0003; ec[0] = 1;
    for (int k = 0; k < 6; k++) begin
      rmem[12'h010 + k] = 32'(k + 1);
      ea[k+1] = 12'h101 + 12'(k); ed[k+1] = 32'(k + 1); ec[k+1] = 4 + k;
    end
    launch(16'd2, 16'd3, 12'h010, 12'h100, 5'd0, 1'b0);
    wait_done("basic");
    checks++;
    if (wq_addr.size() != 7) begin errors++; $display("FAIL basic_wr_count got=%0d exp=7", wq_addr.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= wq_addr.size()) begin
        errors++; $display("FAIL basic_wr%0d missing exp addr=%h data=%h", i, ea[i], ed[i]);
      end else if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i] || wq_cyc[i] != ec[i]) begin
        errors++;
        $display("FAIL basic_wr%0d got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                 i, wq_addr[i], wq_data[i], wq_cyc[i], ea[i], ed[i], ec[i]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rd_log[k+1] !== 12'h010 + 12'(k)) begin
        errors++; $display("FAIL basic_rd_addr cyc%0d got=%h exp=%h", k + 1, rd_log[k+1], 12'h010 + 12'(k));
      end
    end
    checks += 5;
    if (done_cyc != 10) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=10", done_cyc); end
    if (done_n != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_n); end
    if (rdy_log[10] !== 1'b0) begin errors++; $display("FAIL basic_ready_c10 got=%b exp=0", rdy_log[10]); end
    if (rdy_log[11] !== 1'b1) begin errors++; $display("FAIL basic_ready_c11 got=%b exp=1", rdy_log[11]); end
    if (sat_count !== 16'd0) begin errors++; $display("FAIL basic_sat_count got=%0d exp=0", sat_count); end
  endtask

  task automatic test_relu_shift();
    logic [31:0] ed [0:3];
    rmem[12'h020] = 32'hFFFF_FF9C; rmem[12'h021] = 32'h0000_0F00;
    rmem[12'h022] = 32'h7FFF_FFFF; rmem[12'h023] = 32'h0000_000F;
    ed[0] = 32'h0; ed[1] = 32'h0000_00F0; ed[2] = 32'h0000_7FFF; ed[3] = 32'h0;
    launch(16'd1, 16'd4, 12'h020, 12'h200, 5'd4, 1'b1);
    wait_done("relu");
    checks += 3;
    if (wq_addr.size() != 5) begin errors++; $display("FAIL relu_wr_count got=%0d exp=5", wq_addr.size()); end
    else if (wq_addr[0] !== 12'h200 || wq_data[0] !== 32'h0001_0004) begin
      errors++; $display("FAIL relu_header got addr=%h data=%h exp addr=200 data=00010004", wq_addr[0], wq_data[0]);
    end
    if (done_cyc != 8) begin errors++; $display("FAIL relu_done_cycle got=%0d exp=8", done_cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i + 1 >= wq_addr.size()) begin
        errors++; $display("FAIL relu_wr%0d missing exp data=%h", i, ed[i]);
      end else if (wq_addr[i+1] !== 12'h201 + 12'(i) || wq_data[i+1] !== ed[i] || wq_cyc[i+1] != 4 + i) begin
        errors++;
        $display("FAIL relu_wr%0d got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                 i, wq_addr[i+1], wq_data[i+1], wq_cyc[i+1], 12'h201 + 12'(i), ed[i], 4 + i);
      end
    end
    checks++;
    if (sat_count !== 16'd1) begin errors++; $display("FAIL relu_sat_count got=%0d exp=1", sat_count); end
  endtask

  task automatic test_saturate();
    logic [31:0] ed [0:2];
    rmem[12'h030] = 32'hFFFF_0000; rmem[12'h031] = 32'h0000_8000; rmem[12'h032] = 32'hFFFF_8000;
    ed[0] = 32'hFFFF_8000; ed[1] = 32'h0000_7FFF; ed[2] = 32'hFFFF_8000;
    launch(16'd1, 16'd3, 12'h030, 12'h280, 5'd0, 1'b0);
    wait_done("sat");
    checks++;
    if (wq_addr.size() != 4) begin errors++; $display("FAIL sat_wr_count got=%0d exp=4", wq_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i + 1 >= wq_addr.size()) begin
        errors++; $display("FAIL sat_wr%0d missing exp data=%h", i, ed[i]);
      end else if (wq_addr[i+1] !== 12'h281 + 12'(i) || wq_data[i+1] !== ed[i]) begin
        errors++;
        $display("FAIL sat_wr%0d got addr=%h data=%h exp addr=%h data=%h",
                 i, wq_addr[i+1], wq_data[i+1], 12'h281 + 12'(i), ed[i]);
      end
    end
    checks++;
    if (sat_count !== 16'd2) begin errors++; $display("FAIL sat_sat_count got=%0d exp=2", sat_count); end
  endtask

  task automatic test_arith_shift();
    logic [31:0] ed [0:1];
    rmem[12'h038] = 32'hFFFF_FF9C; rmem[12'h039] = 32'hFFFF_FFF9;
    ed[0] = 32'hFFFF_FFE7; ed[1] = 32'hFFFF_FFFE;
    launch(16'd1, 16'd2, 12'h038, 12'h2C0, 5'd2, 1'b0);
    wait_done("ashift");
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i + 1 >= wq_addr.size()) begin
        errors++; $display("FAIL ashift_wr%0d missing exp data=%h", i, ed[i]);
      end else if (wq_data[i+1] !== ed[i]) begin
        errors++; $display("FAIL ashift_wr%0d got data=%h exp data=%h", i, wq_data[i+1], ed[i]);
      end
    end
    checks++;
    if (sat_count !== 16'd0) begin errors++; $display("FAIL ashift_sat_count got=%0d exp=0", sat_count); end
  endtask

  task automatic test_empty();
    launch(16'd0, 16'd5, 12'h040, 12'h300, 5'd0, 1'b0);
    wait_done("empty");
    checks += 4;
    if (wq_addr.size() != 1) begin errors++; $display("FAIL empty_wr_count got=%0d exp=1", wq_addr.size()); end
    else if (wq_addr[0] !== 12'h300 || wq_data[0] !== 32'h0000_0005 || wq_cyc[0] != 1) begin
      errors++; $display("FAIL empty_header got addr=%h data=%h cyc=%0d exp addr=300 data=00000005 cyc=1",
                         wq_addr[0], wq_data[0], wq_cyc[0]);
    end
    if (done_cyc != 1) begin errors++; $display("FAIL empty_done_cycle got=%0d exp=1", done_cyc); end
    if (done_n != 1) begin errors++; $display("FAIL empty_done_pulses got=%0d exp=1", done_n); end
    if (rdy_log[3] !== 1'b1) begin errors++; $display("FAIL empty_ready_c3 got=%b exp=1", rdy_log[3]); end
    for (int c = 1; c < 4; c++) begin
      checks++;
      if (rd_log[c] !== 12'h040) begin errors++; $display("FAIL empty_rd_addr cyc%0d got=%h exp=040", c, rd_log[c]); end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] er [0:3];
    logic [11:0] ea [0:4];
    er[0] = 12'hFFE; er[1] = 12'hFFF; er[2] = 12'h000; er[3] = 12'h001;
    ea[0] = 12'hFFD; ea[1] = 12'hFFE; ea[2] = 12'hFFF; ea[3] = 12'h000; ea[4] = 12'h001;
    for (int k = 0; k < 4; k++) rmem[er[k]] = 32'h0000_00A0 + 32'(k);
    launch(16'd2, 16'd2, 12'hFFE, 12'hFFD, 5'd0, 1'b0);
    wait_done("wrap");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_log[k+1] !== er[k]) begin errors++; $display("FAIL wrap_rd%0d got=%h exp=%h", k, rd_log[k+1], er[k]); end
    end
    checks++;
    if (wq_addr.size() != 5) begin errors++; $display("FAIL wrap_wr_count got=%0d exp=5", wq_addr.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= wq_addr.size()) begin
        errors++; $display("FAIL wrap_wr%0d missing exp addr=%h", i, ea[i]);
      end else if (wq_addr[i] !== ea[i] || (i > 0 && wq_data[i] !== 32'h0000_00A0 + 32'(i - 1))) begin
        errors++; $display("FAIL wrap_wr%0d got addr=%h data=%h exp addr=%h", i, wq_addr[i], wq_data[i], ea[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int i;
    rmem[12'h060] = 32'd7;
    rmem[12'h061] = 32'd9;
    launch(16'd1, 16'd1, 12'h060, 12'h500, 5'd0, 1'b0);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (done !== 1'b1 && i < 100);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1 (timeout)", done); end
    num_rows = 16'd1; num_cols = 16'd1; src_base = 12'h061; dst_base = 12'h580; start = 1'b1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_at_done got=%b exp=0", ready); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done got=%b exp=1", ready); end
    @(posedge clk);
    job_cyc = 0; done_n = 0; done_cyc = -1;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    #1 start = 1'b0;
    wait_done("b2b");
    checks += 3;
    if (wq_addr.size() != 2) begin errors++; $display("FAIL b2b_wr_count got=%0d exp=2", wq_addr.size()); end
    else begin
      if (wq_addr[0] !== 12'h580 || wq_data[0] !== 32'h0001_0001 || wq_cyc[0] != 1) begin
        errors++; $display("FAIL b2b_header got addr=%h data=%h cyc=%0d exp addr=580 data=00010001 cyc=1",
                           wq_addr[0], wq_data[0], wq_cyc[0]);
      end
      if (wq_addr[1] !== 12'h581 || wq_data[1] !== 32'd9 || wq_cyc[1] != 4) begin
        errors++; $display("FAIL b2b_elem got addr=%h data=%h cyc=%0d exp addr=581 data=00000009 cyc=4",
                           wq_addr[1], wq_data[1], wq_cyc[1]);
      end
    end
    if (done_cyc != 5) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=5", done_cyc); end
  endtask

  task automatic test_reset_midjob();
    int n_at_reset;
    for (int k = 0; k < 16; k++) rmem[12'h070 + k] = 32'(100 + k);
    launch(16'd4, 16'd4, 12'h070, 12'h400, 5'd0, 1'b0);
    @(negedge clk);                      // cycle 0
    @(negedge clk);                      // cycle 1
    @(negedge clk);                      // cycle 2: ignored start
    start = 1'b1; dst_base = 12'h600; num_rows = 16'd1;
    @(negedge clk);                      // cycle 3
    start = 1'b0;
    @(negedge clk);                      // cycle 4
    @(negedge clk);                      // cycle 5
    #2 reset_n = 1'b0;
    #1;
    n_at_reset = wq_addr.size();
    checks += 4;
    if (scr_we !== 1'b0) begin errors++; $display("FAIL midrst_scr_we got=%b exp=0", scr_we); end
    if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    if (result_rd_addr !== 12'h000) begin errors++; $display("FAIL midrst_rd_addr got=%h exp=000", result_rd_addr); end
    if (n_at_reset != 3) begin errors++; $display("FAIL midrst_wr_before got=%0d exp=3", n_at_reset); end
    else begin
      checks++;
      if (wq_addr[0] !== 12'h400 || wq_addr[1] !== 12'h401 || wq_addr[2] !== 12'h402 ||
          wq_data[1] !== 32'd100 || wq_data[2] !== 32'd101) begin
        errors++; $display("FAIL midrst_writes got addr=%h,%h,%h data=%h,%h exp addr=400,401,402 data=64,65",
                           wq_addr[0], wq_addr[1], wq_addr[2], wq_data[1], wq_data[2]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks += 3;
    if (wq_addr.size() != n_at_reset) begin
      errors++; $display("FAIL midrst_no_writes got=%0d exp=%0d", wq_addr.size(), n_at_reset);
    end
    if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got=%b exp=1", ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL midrst_done_after got=%b exp=0", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_shift();
    test_saturate();
    test_arith_shift();
    test_empty();
    test_wrap();
    test_back_to_back();
    test_reset_midjob();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
